// File: rtl/counter_dispatch.sv
// Service-counter stage: pops the customer FIFO head into the lowest idle counter,
// counts service time down on a slow tick, and reports completions and totals.
module counter_dispatch #(
  parameter int DT_SZ = 4,
  parameter int NCNT  = 2,
  parameter int SRV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  q_empty,
  input  logic [DT_SZ-1:0]      qn,
  input  logic [DT_SZ-1:0]      qt,
  output logic                  re,
  output logic [NCNT-1:0]       busy,
  output logic [NCNT*DT_SZ-1:0] cur_num,
  output logic [NCNT*DT_SZ-1:0] rem_t,
  output logic [NCNT-1:0]       done,
  output logic [NCNT*DT_SZ-1:0] done_num,
  output logic [SRV_W-1:0]      served
);

  localparam int SEL_W = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int SUM_W = SRV_W + 3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state    [NCNT];
  logic [DT_SZ-1:0] num_r    [NCNT];
  logic [DT_SZ-1:0] rem_r    [NCNT];
  logic [DT_SZ-1:0] dnum_r   [NCNT];
  logic [NCNT-1:0]  done_r;
  logic [SRV_W-1:0] served_r;

  logic [SEL_W-1:0] sel;
  logic             any_idle;

  function automatic logic [2:0] popcount(input logic [NCNT-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NCNT; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  // Dispatch decisions look only at registered busy, so a counter that
  // completes on an edge cannot be selected until the following edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel      = '0;
    any_idle = 1'b0;
    for (int k = 0; k < NCNT; k++) begin
      if (!any_idle && state[k] == IDLE) begin
        sel      = SEL_W'(k);
        any_idle = 1'b1;
      end
    end
  end

  assign re = rst_n & en & ~q_empty & any_idle;

  // NOTE: state registers use non-blocking assignments so every counter sees pre-edge values.
  // NOTE: these per-counter arrays are plain flops, not RAM, so they are all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCNT; k++) begin
        state[k]  <= IDLE;
        num_r[k]  <= '0;
        rem_r[k]  <= '0;
        dnum_r[k] <= '0;
      end
      done_r <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        done_r[k] <= 1'b0;
        case (state[k])
          IDLE: begin
            if (re && sel == SEL_W'(k)) begin
              state[k] <= BUSY;
              num_r[k] <= qn;
              rem_r[k] <= (qt == '0) ? DT_SZ'(1) : qt;
            end
          end
          BUSY: begin
            if (tick) begin
              if (rem_r[k] == DT_SZ'(1)) begin
                state[k]  <= IDLE;
                rem_r[k]  <= '0;
                done_r[k] <= 1'b1;
                dnum_r[k] <= num_r[k];
              end else begin
                rem_r[k] <= rem_r[k] - DT_SZ'(1);
              end
            end
          end
          default: state[k] <= IDLE;
        endcase
      end
    end
  end

  // Completions are totalled one edge after their done pulse, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_r <= '0;
    end else begin
      logic [SUM_W-1:0] sum;
      sum = {3'b000, served_r} + SUM_W'(popcount(done_r));
      if (sum > SUM_W'({SRV_W{1'b1}})) served_r <= '1;
      else                              served_r <= sum[SRV_W-1:0];
    end
  end

  always_comb begin
    busy     = '0;
    cur_num  = '0;
    rem_t    = '0;
    done_num = '0;
    for (int k = 0; k < NCNT; k++) begin
      busy[k]                      = (state[k] == BUSY);
      cur_num[k*DT_SZ +: DT_SZ]    = num_r[k];
      rem_t[k*DT_SZ +: DT_SZ]      = rem_r[k];
      done_num[k*DT_SZ +: DT_SZ]   = dnum_r[k];
    end
  end

  assign done   = done_r;
  assign served = served_r;

endmodule
